// File: rtl/dac_scaler.sv
// Output conditioning between wave memory and the parallel DAC pins: gain about
// mid-scale, DC offset, mute, clamp to DAC range, and a saturating clip counter.
module dac_scaler #(
  parameter int DATA_W = 10,
  parameter int GAIN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic [7:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [7:0]        clip_count
);

  localparam int CW     = DATA_W + 1;           // centered sample width
  localparam int PW     = DATA_W + GAIN_W + 1;  // exact product width
  localparam int SW     = PW + 1;               // stage-2 sum width
  localparam int OFF_W  = 6;
  localparam int OFF_SH = 4;
  localparam int FRAC_W = 3;

  localparam logic [DATA_W-1:0] MID        = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << FRAC_W);

  typedef enum logic [1:0] {
    OP_GAIN   = 2'b00,
    OP_OFFSET = 2'b01,
    OP_MUTE   = 2'b10,
    OP_NONE   = 2'b11
  } op_e;

  op_e op;
  assign op = op_e'(cmd[7:6]);

  logic [GAIN_W-1:0] gain_sh;
  logic [OFF_W-1:0]  offset_sh;
  logic              mute_sh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gain_sh   <= GAIN_UNITY;
      offset_sh <= '0;
      mute_sh   <= 1'b0;
    end else if (cmd_valid) begin
      case (op)
        OP_GAIN:   gain_sh   <= cmd[GAIN_W-1:0];
        OP_OFFSET: offset_sh <= cmd[OFF_W-1:0];
        OP_MUTE:   mute_sh   <= cmd[0];
        default:   ;
      endcase
    end
  end

  // Stage 1: center about mid-scale and multiply by the raw gain code.
  logic signed [CW-1:0] centered;
  logic signed [PW-1:0] centered_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod;

  always_comb begin
    centered     = $signed({1'b0, sample}) - $signed({2'b01, {(DATA_W-1){1'b0}}});
    centered_ext = {{(PW-CW){centered[CW-1]}}, centered};
    gain_ext     = {{(PW-GAIN_W){1'b0}}, gain_sh};
    prod         = centered_ext * gain_ext;
  end

  logic                 s1_v;
  logic signed [PW-1:0] s1_prod;
  logic [OFF_W-1:0]     s1_off;
  logic                 s1_mute;

  // Settings are captured alongside the sample so later commands cannot
  // alter a sample already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s1_prod <= '0;
      s1_off  <= '0;
      s1_mute <= 1'b0;
    end else begin
      s1_v <= sample_valid;
      if (sample_valid) begin
        s1_prod <= prod;
        s1_off  <= offset_sh;
        s1_mute <= mute_sh;
      end
    end
  end

  // Stage 2: rescale, offset, clamp. The shift is done on its own so it
  // stays arithmetic (floor toward -inf).
  logic signed [SW-1:0] prod_ext;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] mid_ext;
  logic signed [SW-1:0] off_ext;
  logic signed [SW-1:0] sum;
  logic [DATA_W-1:0]    result;
  logic                 clip;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prod_ext = {s1_prod[PW-1], s1_prod};
    shifted  = prod_ext >>> FRAC_W;
    mid_ext  = {{(SW-DATA_W){1'b0}}, MID};
    off_ext  = {{(SW-OFF_W-OFF_SH){s1_off[OFF_W-1]}}, s1_off, {OFF_SH{1'b0}}};
    sum      = shifted + mid_ext + off_ext;
    result   = sum[DATA_W-1:0];
    clip     = 1'b0;
    if (sum[SW-1]) begin
      result = '0;
      clip   = 1'b1;
    end else if (|sum[SW-2:DATA_W]) begin
      result = '1;
      clip   = 1'b1;
    end
    if (s1_mute) begin
      result = MID;
      clip   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac_data   <= MID;
      dac_valid  <= 1'b0;
      clip_count <= '0;
    end else begin
      dac_valid <= s1_v;
      if (s1_v) begin
        dac_data <= result;
        if (clip && clip_count != 8'hFF) begin
          clip_count <= clip_count + 8'd1;
        end
      end
    end
  end

endmodule
